// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serialises one byte per accepted write into an asynchronous frame:
//   start bit (0), 8 data bits LSB first, optional even parity bit, and one
//   stop bit (1). An internal divider, selected by baud_select, sets the
//   bit period.
//
// Ports
//   clk          system clock; all logic changes on the rising edge
//   rst          synchronous, active-high reset
//   baud_select  baud code 000..111 = 300/1200/4800/9600/19200/38400/57600/115200
//   Tx_EN        transmitter enable; low forces the idle state
//   Tx_DATA      byte to send; captured on the accept cycle
//   Tx_WR        write strobe; only acted on in IDLE with Tx_EN high
//   TxD          serial line output, registered, idles high
//   Tx_BUSY      registered, high while a frame is in progress
//   dbg_state    current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//
// Handshake: a write is accepted on a rising edge where Tx_WR=1, Tx_EN=1 and
// the FSM is in IDLE. There is no ready output; Tx_BUSY low means the next
// such edge will accept. Writes at any other time are dropped silently.
module uart_transmitter #(
  parameter int CLK_FREQ  = 150000000,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic [7:0] Tx_DATA,
  input  logic       Tx_WR,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Bit-period divisors, truncated. 19 bits covers the 300 baud case at the
  // default clock (500000 cycles).
  localparam logic [18:0] DIV_300    = 19'(CLK_FREQ / 300);
  localparam logic [18:0] DIV_1200   = 19'(CLK_FREQ / 1200);
  localparam logic [18:0] DIV_4800   = 19'(CLK_FREQ / 4800);
  localparam logic [18:0] DIV_9600   = 19'(CLK_FREQ / 9600);
  localparam logic [18:0] DIV_19200  = 19'(CLK_FREQ / 19200);
  localparam logic [18:0] DIV_38400  = 19'(CLK_FREQ / 38400);
  localparam logic [18:0] DIV_57600  = 19'(CLK_FREQ / 57600);
  localparam logic [18:0] DIV_115200 = 19'(CLK_FREQ / 115200);

  // Constant lookup; no divider hardware is built.
  function automatic logic [18:0] div_for(input logic [2:0] code);
    logic [18:0] d;
    case (code)
      3'd0:    d = DIV_300;
      3'd1:    d = DIV_1200;
      3'd2:    d = DIV_4800;
      3'd3:    d = DIV_9600;
      3'd4:    d = DIV_19200;
      3'd5:    d = DIV_38400;
      3'd6:    d = DIV_57600;
      default: d = DIV_115200;
    endcase
    return d;
  endfunction

  state_t      state_q, state_d;
  logic [18:0] cnt_q, cnt_d;     // position within the current bit period
  logic [18:0] div_q, div_d;     // bit period latched at accept
  logic [2:0]  idx_q, idx_d;     // data bit index
  logic [7:0]  shift_q, shift_d; // bit 0 is always the data bit on the line
  logic        par_q, par_d;     // even-parity bit for the latched byte
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        bit_end;

  // Next-state and next-output logic. TxD and Tx_BUSY are computed here and
  // registered below so the pad sees no combinational path from inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    bit_end = (cnt_q == div_q - 19'd1);

    if (!Tx_EN) begin
      // Disable truncates any frame in flight.
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      txd_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          txd_d  = 1'b1;
          busy_d = 1'b0;
          if (Tx_WR) begin
            shift_d = Tx_DATA;
            par_d   = ^Tx_DATA;
            div_d   = div_for(baud_select);
            idx_d   = '0;
            state_d = START;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end

        START: begin
          cnt_d = bit_end ? '0 : cnt_q + 19'd1;
          if (bit_end) begin
            state_d = DATA;
            idx_d   = '0;
            txd_d   = shift_q[0];
          end
        end

        DATA: begin
          cnt_d = bit_end ? '0 : cnt_q + 19'd1;
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              if (PARITY_EN) begin
                state_d = PARITY;
                txd_d   = par_q;
              end else begin
                state_d = STOP;
                txd_d   = 1'b1;
              end
            end else begin
              idx_d   = idx_q + 3'd1;
              shift_d = {1'b0, shift_q[7:1]};
              txd_d   = shift_q[1];
            end
          end
        end

        PARITY: begin
          cnt_d = bit_end ? '0 : cnt_q + 19'd1;
          if (bit_end) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end
        end

        STOP: begin
          cnt_d = bit_end ? '0 : cnt_q + 19'd1;
          if (bit_end) begin
            // Back in IDLE only after this edge, so the next accept is at
            // least one clock later: a guaranteed idle-high gap.
            state_d = IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign TxD       = txd_q;
  assign Tx_BUSY   = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter. Three instances share the input stimulus:
//   dut 0: default clock (150 MHz), parity on  -> code 111 divisor 1302
//   dut 1: 1.2 MHz clock, parity on            -> short frames, rate sweep
//   dut 2: default clock, parity off           -> 10-bit frame
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] baud;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic [2:0] txd_v;
  logic [2:0] busy_v;
  logic [2:0] dbg_a, dbg_b, dbg_c;

  int errors = 0;
  int checks = 0;

  // Hand-computed divisors for CLK_FREQ = 1_200_000, truncated.
  int exp_div[8] = '{4000, 1000, 250, 125, 62, 31, 20, 10};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs ----------------
  uart_transmitter u_dut_a (
    .clk(clk), .rst(rst), .baud_select(baud), .Tx_EN(tx_en), .Tx_DATA(tx_data),
    .Tx_WR(tx_wr), .TxD(txd_v[0]), .Tx_BUSY(busy_v[0]), .dbg_state(dbg_a)
  );

  uart_transmitter #(.CLK_FREQ(1_200_000), .PARITY_EN(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .baud_select(baud), .Tx_EN(tx_en), .Tx_DATA(tx_data),
    .Tx_WR(tx_wr), .TxD(txd_v[1]), .Tx_BUSY(busy_v[1]), .dbg_state(dbg_b)
  );

  uart_transmitter #(.PARITY_EN(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .baud_select(baud), .Tx_EN(tx_en), .Tx_DATA(tx_data),
    .Tx_WR(tx_wr), .TxD(txd_v[2]), .Tx_BUSY(busy_v[2]), .dbg_state(dbg_c)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Pulse a write; returns at the sample point just after the accept edge.
  task automatic send(input logic [7:0] data);
    tx_data = data;
    tx_wr   = 1'b1;
    tick();
    tx_wr   = 1'b0;
  endtask

  // Called at the sample after the accept edge. Checks every bit level and
  // its exact duration, the busy length, and the idle state after the frame.
  // poke_at > 0 injects a stray write of 0xFF and a baud change to 000.
  task automatic watch_frame(input int id, input logic [7:0] data, input int div,
                             input int nbits, input int poke_at);
    logic [10:0] lv;
    int busy_cnt;
    int hold_bad;
    int s;
    lv[0]   = 1'b0;
    lv[8:1] = data;
    lv[9]   = (nbits == 11) ? ^data : 1'b1;
    lv[10]  = 1'b1;
    busy_cnt = 0;
    s = 0;
    for (int b = 0; b < nbits; b++) begin
      check($sformatf("dut%0d %02h bit%0d level", id, data, b), 32'(txd_v[id]), 32'(lv[b]));
      hold_bad = 0;
      for (int c = 0; c < div; c++) begin
        if (txd_v[id] !== lv[b]) hold_bad++;
        if (busy_v[id] === 1'b1) busy_cnt++;
        if (poke_at > 0 && s == poke_at) begin
          tx_wr   = 1'b1;
          tx_data = 8'hFF;
          baud    = 3'b000;
        end else if (poke_at > 0 && s == poke_at + 1) begin
          tx_wr = 1'b0;
        end
        s++;
        tick();
      end
      check($sformatf("dut%0d %02h bit%0d hold errors", id, data, b), 32'(hold_bad), 32'd0);
    end
    check($sformatf("dut%0d %02h busy cycles", id, data), 32'(busy_cnt), 32'(nbits * div));
    check($sformatf("dut%0d %02h busy after", id, data), 32'(busy_v[id]), 32'd0);
    check($sformatf("dut%0d %02h txd after", id, data), 32'(txd_v[id]), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int w;

    rst     = 1'b1;
    tx_en   = 1'b0;
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    baud    = 3'b111;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset txd dut%0d", i), 32'(txd_v[i]), 32'd1);
      check($sformatf("reset busy dut%0d", i), 32'(busy_v[i]), 32'd0);
    end
    rst   = 1'b0;
    tx_en = 1'b1;
    tick();

    // Basic frame at 115200 from 150 MHz: 0x55, parity 0, 11 x 1302 cycles.
    send(8'h55);
    watch_frame(0, 8'h55, 1302, 11, 0);

    // No-parity instance: 10-bit frame, 13020 busy cycles.
    do_reset();
    send(8'hA5);
    watch_frame(2, 8'hA5, 1302, 10, 0);

    // Parity bit values on the fast instance (DIV = 10 at code 111).
    do_reset();
    send(8'h07);
    watch_frame(1, 8'h07, 10, 11, 0);
    do_reset();
    send(8'h00);
    watch_frame(1, 8'h00, 10, 11, 0);

    // Stray write and baud change during DATA leave the frame untouched.
    do_reset();
    baud = 3'b111;
    send(8'h96);
    watch_frame(1, 8'h96, 10, 11, 35);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (txd_v[1] !== 1'b1 || busy_v[1] !== 1'b0) bad++;
      tick();
    end
    check("no second frame", 32'(bad), 32'd0);
    baud = 3'b111;

    // Back-to-back with Tx_WR held: second start one clock after busy falls.
    do_reset();
    tx_data = 8'h3C;
    tx_wr   = 1'b1;
    tick();
    tx_data = 8'hC3;
    watch_frame(1, 8'h3C, 10, 11, 0);
    tick();
    tx_wr = 1'b0;
    check("b2b second start txd", 32'(txd_v[1]), 32'd0);
    check("b2b second start busy", 32'(busy_v[1]), 32'd1);
    watch_frame(1, 8'hC3, 10, 11, 0);

    // Reset mid-frame abandons it at the first sampled edge.
    do_reset();
    send(8'h00);
    repeat (15) tick();
    check("pre-reset txd", 32'(txd_v[1]), 32'd0);
    rst = 1'b1;
    tick();
    check("mid reset txd", 32'(txd_v[1]), 32'd1);
    check("mid reset busy", 32'(busy_v[1]), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (txd_v[1] !== 1'b1 || busy_v[1] !== 1'b0) bad++;
      tick();
    end
    check("after reset quiet", 32'(bad), 32'd0);

    // Simultaneous reset and write: reset wins.
    rst     = 1'b1;
    tx_wr   = 1'b1;
    tx_data = 8'h00;
    tick();
    check("rst+wr busy", 32'(busy_v[1]), 32'd0);
    check("rst+wr txd", 32'(txd_v[1]), 32'd1);
    rst   = 1'b0;
    tx_wr = 1'b0;
    tick();
    check("rst+wr busy later", 32'(busy_v[1]), 32'd0);

    // Write with Tx_EN low is ignored.
    tx_en = 1'b0;
    tx_wr = 1'b1;
    tick();
    tx_wr = 1'b0;
    check("disabled write busy", 32'(busy_v[1]), 32'd0);
    tick();
    check("disabled write txd", 32'(txd_v[1]), 32'd1);
    tx_en = 1'b1;

    // Dropping Tx_EN during DATA truncates on the next edge.
    do_reset();
    send(8'h00);
    repeat (13) tick();
    check("pre-abort txd", 32'(txd_v[1]), 32'd0);
    tx_en = 1'b0;
    tick();
    check("abort txd", 32'(txd_v[1]), 32'd1);
    check("abort busy", 32'(busy_v[1]), 32'd0);
    tx_en = 1'b1;
    tick();
    check("abort stays idle", 32'(busy_v[1]), 32'd0);

    // Start-bit width for every baud code.
    for (int code = 0; code < 8; code++) begin
      do_reset();
      baud = 3'(code);
      send(8'hFF);
      w = 0;
      while (txd_v[1] === 1'b0 && w < 5000) begin
        w++;
        tick();
      end
      check($sformatf("sweep code %0d start width", code), 32'(w), 32'(exp_div[code]));
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- UART transmit path; the counterpart of the receiver and its 16x sample-enable baud controller.
- Serialises one byte per write request into an asynchronous frame: start bit, 8 data bits LSB first, optional even parity bit, one stop bit.
- Contains its own bit-period divider driven by the same 3-bit baud_select encoding as the receive side.
- Sits between the host write interface and the TxD pad.

Parameters:
CLK_FREQ, 150000000, system clock frequency in Hz; used to compute bit-period divisors.
PARITY_EN, 1, 1 = insert even parity bit (11-bit frame); 0 = no parity (10-bit frame).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
baud_select  input  3  baud-rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 bit/s.
Tx_EN  input  1  transmitter enable; low forces idle.
Tx_DATA  input  8  byte to send; sampled on the accept cycle.
Tx_WR  input  1  write strobe; request to send Tx_DATA.
TxD  output  1  serial line; idles high.
Tx_BUSY  output  1  high while a frame is in progress.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- Reset values: TxD=1, Tx_BUSY=0, state=IDLE, divider counter=0, bit index=0, shift register=0.
- Reset mid-frame: the frame is abandoned. TxD=1 and Tx_BUSY=0 from the edge at which rst is sampled high.
- Divisor: DIV = CLK_FREQ / baud (integer, truncated).
  - At the default CLK_FREQ, DIV is 500000, 125000, 31250, 15625, 7812, 3906, 2604, 1302 for codes 000..111.
  - Divider counter is 19 bits, sized for the largest DIV.
  - baud_select is latched on the accept cycle. Changes during a frame have no effect until the next accept.
- Accept: Tx_WR=1 and Tx_EN=1 and state=IDLE at edge k.
  - At edge k: Tx_DATA, parity (XOR of Tx_DATA bits) and DIV are latched; state <= START; TxD <= 0; Tx_BUSY <= 1; divider counter <= 0.
  - Tx_WR at any other time is ignored. There is no queueing and no error flag.
- Bit timing: every bit is held on TxD for exactly DIV clock cycles.
  - Divider counts 0..DIV-1. At DIV-1 it wraps to 0 and the FSM advances on that same edge.
- States:
  - IDLE: TxD=1, Tx_BUSY=0.
  - START: TxD=0, for one bit period, then -> DATA with bit index 0.
  - DATA: TxD = data[index], index 0..7. Index increments at each bit boundary. After index 7: -> PARITY if PARITY_EN=1, else -> STOP.
  - PARITY: TxD = even-parity bit, so the total number of ones in data+parity is even. One bit period, then -> STOP.
  - STOP: TxD=1, for one bit period, then -> IDLE. Tx_BUSY <= 0 on the same edge.
- Frame length: Tx_BUSY is high for exactly 11*DIV cycles (10*DIV when PARITY_EN=0), from edge k to edge k+11*DIV.
- Back-to-back frames: the earliest next accept is edge k+11*DIV+1. This guarantees at least one idle-high clock between frames beyond the stop bit.
- Tx_EN dropped mid-frame: on the next edge, state -> IDLE, TxD=1, Tx_BUSY=0, divider counter cleared. The frame is truncated.
- Tx_EN=0 in IDLE: Tx_WR is ignored.
- Simultaneous rst and Tx_WR: rst wins; no frame starts.
- Outputs are registered; no combinational path from inputs to TxD or Tx_BUSY.

Test Plan:
- Reset: assert rst for 3 cycles during an active frame -> TxD=1, Tx_BUSY=0 at the first sampled edge; no further line transitions.
- Basic frame: Tx_EN=1, baud_select=111, write 0x55 -> TxD sequence 0,1,0,1,0,1,0,1,0, parity 0, stop 1. Each level lasts exactly 1302 clk cycles; Tx_BUSY high for 14322 cycles.
- Parity: write 0x07 -> parity bit 1; write 0x00 -> parity bit 0. With PARITY_EN=0, write 0xA5 -> 10-bit frame with Tx_BUSY high for 13020 cycles (code 111).
- Ignored writes and baud changes: pulse Tx_WR with 0xFF mid-frame, and change baud_select to 000 mid-frame -> current frame bits and timing unchanged; no second frame.
- Back-to-back frames: hold Tx_WR=1 with 0x3C then 0xC3 -> second start bit begins exactly 1 cycle after Tx_BUSY falls.
- Rate sweep and abort: for each baud_select code, measure start-bit width -> equals the DIV table value. Drop Tx_EN during DATA -> TxD=1 and Tx_BUSY=0 on the next edge.
